// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller states
// and the legal operand width range.
package arith_pkg;

  // Legal operand width range for the serial engines
  localparam int MIN_W = 2;
  localparam int MAX_W = 32;

  // Controller states: wait for a request, walk the bits, present the result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit is the parity of all three inputs
  assign d = a ^ b ^ bin;

  // Borrow when b exceeds a, or when they match and a borrow arrives
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor. Computes a - b LSB-first through a
// single full-subtractor cell over WIDTH cycles, framed by start/busy/done.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  // Reject unsupported widths while elaborating
  if (WIDTH < MIN_W || WIDTH > MAX_W) begin : g_bad_width
    $error("serial_subtractor: WIDTH=%0d outside legal range %0d..%0d",
           WIDTH, MIN_W, MAX_W);
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bin_q;      // running borrow between bit positions
  logic             a_msb_q;    // operand sign bits kept for the overflow flag
  logic             b_msb_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;   // final borrow-out presented with done
  logic             ovf_q;

  logic             diff_bit_d;
  logic             borrow_bit_d;
  logic             last_bit;

  // Single shared arithmetic cell working on the current LSBs
  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (bin_q),
    .d    (diff_bit_d),
    .bout (borrow_bit_d)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Controller, datapath shift registers and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // Accept: capture operands and restart the bit walk
            a_sr_q  <= a;
            b_sr_q  <= b;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            bin_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          diff_q <= {diff_bit_d, diff_q[WIDTH-1:1]};
          bin_q  <= borrow_bit_d;
          if (last_bit) begin
            // MSB processed: freeze flags and announce the result
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            borrow_q <= borrow_bit_d;
            ovf_q    <= (a_msb_q != b_msb_q) && (diff_bit_d != a_msb_q);
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule
